// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the PLL lock/reset sequencer and its clock-enable dividers.
package clk_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        STABLE = 2'd1,
        HOLD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Ceiling log2 with a floor of 1, used to size the sequencing counters.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One clock-enable channel: holds its divide ratio and a down-counter that
// produces a single-cycle ce pulse every 'div' cycles while the sequencer is in RUN.
// A restart forces a pulse on the following cycle so all channels share phase.
module clk_div_ch #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    input  logic             restart,
    input  logic             run,
    output logic             ce
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_eff_s;
    logic [DIV_W-1:0] reload_s;

    // Pick the ratio in effect this edge (a fresh load takes effect at once) and derive the counter reload.
    always_comb begin
        div_eff_s = div_r;
        reload_s  = '0;
        if (load) begin
            div_eff_s = div_in;
        end else begin
            div_eff_s = div_r;
        end
        if (div_eff_s <= DIV_W'(1)) begin
            reload_s = '0;
        end else begin
            reload_s = div_eff_s - DIV_W'(1);
        end
    end

    // Ratio register plus the down-counter; ce fires whenever the counter wraps or a restart is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= DIV_W'(1);
            cnt_r <= '0;
            ce    <= 1'b0;
        end else begin
            if (load) begin
                div_r <= div_in;
            end else begin
                div_r <= div_r;
            end
            if (!run) begin
                cnt_r <= '0;
                ce    <= 1'b0;
            end else if (restart || (cnt_r == '0)) begin
                cnt_r <= reload_s;
                ce    <= 1'b1;
            end else begin
                cnt_r <= cnt_r - DIV_W'(1);
                ce    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pll_clk_en_seq.sv
// Lock-qualified reset sequencer and NCH-channel clock-enable generator.
// The PLL lock flag is synchronised, must stay high for STABLE_CYC cycles,
// then rst_out is held for HOLD_CYC more cycles before RUN releases the fabric.
// Optional macro CLK_SEQ_STATUS_EN adds the saturating lock_loss_cnt output.
module pll_clk_en_seq
    import clk_seq_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DIV_W      = 8,
    parameter int STABLE_CYC = 1024,
    parameter int HOLD_CYC   = 16,
    parameter int CNT_W      = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 locked,
    input  logic [NCH*DIV_W-1:0] div_cfg,
    input  logic                 cfg_load,
    output logic                 rst_out,
    output logic                 running,
    output logic [STATE_W-1:0]   state_o,
    output logic [NCH-1:0]       ce
`ifdef CLK_SEQ_STATUS_EN
    ,
    output logic [CNT_W-1:0]     lock_loss_cnt
`endif
);

    localparam int MAX_CYC = (STABLE_CYC > HOLD_CYC) ? STABLE_CYC : HOLD_CYC;
    localparam int SEQ_W   = clog2(MAX_CYC) + 1;

    logic             sync1_r;
    logic             locked_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [SEQ_W-1:0] seq_cnt_r;
    logic [SEQ_W-1:0] seq_cnt_nxt_s;
    logic             loss_s;
    logic             run_nxt_s;
    logic             restart_s;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_r  <= locked;
            locked_s <= sync1_r;
        end
    end

    // Next-state logic: lock qualification window, reset tail, and lock-loss detection.
    always_comb begin
        state_nxt_s   = state_r;
        seq_cnt_nxt_s = '0;
        loss_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (locked_s) begin
                    state_nxt_s = STABLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt_s = IDLE;
                end else if (seq_cnt_r == SEQ_W'(STABLE_CYC - 1)) begin
                    state_nxt_s = HOLD;
                end else begin
                    seq_cnt_nxt_s = seq_cnt_r + SEQ_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt_s = IDLE;
                end else if (seq_cnt_r == SEQ_W'(HOLD_CYC - 1)) begin
                    state_nxt_s = RUN;
                end else begin
                    seq_cnt_nxt_s = seq_cnt_r + SEQ_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt_s = IDLE;
                    loss_s      = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and sequencing counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r   <= IDLE;
            seq_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            seq_cnt_r <= seq_cnt_nxt_s;
        end
    end

    // Registered status outputs, decoded from the next state so they line up with state_o.
    always_ff @(posedge refclk) begin
        if (rst) begin
            rst_out <= 1'b1;
            running <= 1'b0;
        end else begin
            rst_out <= (state_nxt_s != RUN);
            running <= (state_nxt_s == RUN);
        end
    end

    assign state_o = state_r;

    // Dividers run whenever the next state is RUN; they restart on RUN entry or on a reload while running.
    always_comb begin
        run_nxt_s = (state_nxt_s == RUN);
        if (run_nxt_s && ((state_r != RUN) || cfg_load)) begin
            restart_s = 1'b1;
        end else begin
            restart_s = 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W (DIV_W)
        ) u_div (
            .clk     (refclk),
            .rst     (rst),
            .load    (cfg_load),
            .div_in  (div_cfg[i*DIV_W +: DIV_W]),
            .restart (restart_s),
            .run     (run_nxt_s),
            .ce      (ce[i])
        );
    end

`ifdef CLK_SEQ_STATUS_EN
    // Saturating count of lock losses seen while running.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (loss_s && (lock_loss_cnt != {CNT_W{1'b1}})) begin
            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
        end else begin
            lock_loss_cnt <= lock_loss_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pll_clk_en_seq.sv
// Directed testbench for pll_clk_en_seq (NCH=2, DIV_W=4, STABLE_CYC=8, HOLD_CYC=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_pll_clk_en_seq;

    localparam int NCH   = 2;
    localparam int DIV_W = 4;
    localparam int CNT_W = 8;

    logic                 refclk;
    logic                 rst;
    logic                 locked;
    logic [NCH*DIV_W-1:0] div_cfg;
    logic                 cfg_load;
    logic                 rst_out;
    logic                 running;
    logic [1:0]           state_o;
    logic [NCH-1:0]       ce;
`ifdef CLK_SEQ_STATUS_EN
    logic [CNT_W-1:0]     lock_loss_cnt;
`endif

    int checks;
    int errors;

    pll_clk_en_seq #(
        .NCH        (NCH),
        .DIV_W      (DIV_W),
        .STABLE_CYC (8),
        .HOLD_CYC   (4),
        .CNT_W      (CNT_W)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .div_cfg  (div_cfg),
        .cfg_load (cfg_load),
        .rst_out  (rst_out),
        .running  (running),
        .state_o  (state_o),
        .ce       (ce)
`ifdef CLK_SEQ_STATUS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        locked = 1'b0;
        cfg_load = 1'b0;
        tickn(2);
        rst = 1'b0;
    endtask

    // Raise lock right after an edge (edge 0) and run 15 edges: RUN from then on.
    task automatic bring_up();
        locked = 1'b1;
        tickn(15);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rst_out !== 1'b1 || running !== 1'b0 || state_o !== 2'd0 || ce !== 2'b00) begin
            errors++;
            $display("FAIL reset: rst_out=%b running=%b state=%0d ce=%b, want 1 0 0 00", rst_out, running, state_o, ce);
        end
`ifdef CLK_SEQ_STATUS_EN
        checks++;
        if (lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_lockup();
        do_reset();
        locked = 1'b1;
        tickn(2);
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL lockup_e2: state=%0d want 0", state_o); end
        tick();
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL lockup_e3: state=%0d want 1", state_o); end
        tickn(7);
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL lockup_e10: state=%0d want 1", state_o); end
        tick();
        checks++;
        if (state_o !== 2'd2 || rst_out !== 1'b1) begin errors++; $display("FAIL lockup_e11: state=%0d rst_out=%b want 2 1", state_o, rst_out); end
        tickn(3);
        checks++;
        if (state_o !== 2'd2 || rst_out !== 1'b1 || ce !== 2'b00) begin
            errors++; $display("FAIL lockup_e14: state=%0d rst_out=%b ce=%b want 2 1 00", state_o, rst_out, ce);
        end
        tick();
        checks++;
        if (state_o !== 2'd3 || rst_out !== 1'b0 || running !== 1'b1 || ce !== 2'b11) begin
            errors++; $display("FAIL lockup_e15: state=%0d rst_out=%b running=%b ce=%b want 3 0 1 11", state_o, rst_out, running, ce);
        end
        tick();
        checks++;
        if (ce !== 2'b11) begin errors++; $display("FAIL lockup_div1: ce=%b want 11", ce); end
    endtask

    task automatic test_glitch();
        do_reset();
        locked = 1'b1;
        tickn(5);
        locked = 1'b0;
        tickn(3);
        locked = 1'b1;
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL glitch_idle: state=%0d want 0", state_o); end
        tickn(3);
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL glitch_restable: state=%0d want 1", state_o); end
        tickn(7);
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL glitch_cnt_restart: state=%0d want 1", state_o); end
        tick();
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL glitch_hold: state=%0d want 2", state_o); end
`ifdef CLK_SEQ_STATUS_EN
        checks++;
        if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL glitch_cnt: got %0d want 0", lock_loss_cnt); end
`endif
    endtask

    task automatic test_divide();
        logic [1:0] exp;
        do_reset();
        bring_up();
        div_cfg = {4'd3, 4'd1};
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp = {((k % 3) == 0) ? 1'b1 : 1'b0, 1'b1};
            checks++;
            if (ce !== exp) begin errors++; $display("FAIL divide_c%0d: ce=%b want %b", k, ce, exp); end
            tick();
        end
    endtask

    task automatic test_reload();
        logic [1:0] exp;
        div_cfg = {4'd2, 4'd5};
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int k = 0; k < 11; k++) begin
            exp = {((k % 2) == 0) ? 1'b1 : 1'b0, ((k % 5) == 0) ? 1'b1 : 1'b0};
            checks++;
            if (ce !== exp) begin errors++; $display("FAIL reload_c%0d: ce=%b want %b", k, ce, exp); end
            tick();
        end
    endtask

    task automatic test_loss();
        logic [1:0] seq_exp [4];
        seq_exp[0] = 2'b11; seq_exp[1] = 2'b10; seq_exp[2] = 2'b10; seq_exp[3] = 2'b11;
        do_reset();
        bring_up();
        locked = 1'b0;
        tickn(2);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL loss_e2: running=%b want 1", running); end
        div_cfg = {4'd1, 4'd3};
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        checks++;
        if (rst_out !== 1'b1 || ce !== 2'b00 || state_o !== 2'd0 || running !== 1'b0) begin
            errors++; $display("FAIL loss_e3: rst_out=%b ce=%b state=%0d running=%b want 1 00 0 0", rst_out, ce, state_o, running);
        end
`ifdef CLK_SEQ_STATUS_EN
        checks++;
        if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt1: got %0d want 1", lock_loss_cnt); end
`endif
        for (int n = 2; n <= 300; n++) begin
            bring_up();
            if (n == 2) begin
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (ce !== seq_exp[k]) begin errors++; $display("FAIL loss_newdiv_c%0d: ce=%b want %b", k, ce, seq_exp[k]); end
                    tick();
                end
            end else begin
                checks++;
                if (state_o !== 2'd3) begin errors++; $display("FAIL loss_relock%0d: state=%0d want 3", n, state_o); end
            end
            locked = 1'b0;
            tickn(3);
            checks++;
            if (rst_out !== 1'b1 || ce !== 2'b00) begin
                errors++; $display("FAIL loss_drop%0d: rst_out=%b ce=%b want 1 00", n, rst_out, ce);
            end
`ifdef CLK_SEQ_STATUS_EN
            if (n == 254 || n == 255 || n == 256 || n == 300) begin
                checks++;
                if (lock_loss_cnt !== ((n > 255) ? 8'd255 : 8'(n))) begin
                    errors++; $display("FAIL loss_sat%0d: got %0d want %0d", n, lock_loss_cnt, (n > 255) ? 255 : n);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        locked = 1'b1;
        tickn(12);
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL rsthold_pre: state=%0d want 2", state_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rst_out !== 1'b1 || state_o !== 2'd0 || ce !== 2'b00 || running !== 1'b0) begin
            errors++; $display("FAIL rsthold_post: rst_out=%b state=%0d ce=%b running=%b want 1 0 00 0", rst_out, state_o, ce, running);
        end
        tickn(2);
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL rsthold_e2: state=%0d want 0", state_o); end
        tick();
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL rsthold_e3: state=%0d want 1", state_o); end
        tickn(8);
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL rsthold_e11: state=%0d want 2", state_o); end
        tickn(4);
        checks++;
        if (state_o !== 2'd3 || rst_out !== 1'b0 || ce !== 2'b11) begin
            errors++; $display("FAIL rsthold_e15: state=%0d rst_out=%b ce=%b want 3 0 11", state_o, rst_out, ce);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        locked = 1'b0;
        div_cfg = '0;
        cfg_load = 1'b0;
        test_reset();
        test_lockup();
        test_glitch();
        test_divide();
        test_reload();
        test_loss();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
